// File: rtl/apb_i2c_slave_if.sv
// APB-side bus bundle for the I2C control slave.
// Ports (all signals): sel, enable, write, addr, wdata (master -> slave);
// rdata, ready (slave -> master).
interface apb_i2c_slave_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
);
  logic [1:0]        sel;
  logic              enable;
  logic              write;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              ready;

  modport master (
    output sel, enable, write, addr, wdata,
    input  rdata, ready
  );

  modport slave (
    input  sel, enable, write, addr, wdata,
    output rdata, ready
  );
endinterface

// File: rtl/apb_i2c_slave.sv
// APB slave exposing the I2C master engine register file: CTRL, ADDR, a
// TX FIFO feeding the engine, an RX holding register and sticky status.
// Ports:
//   clk, reset        clock (rising edge), async active-low reset
//   bus               APB slave modport (sel/enable/write/addr/wdata in,
//                     rdata/ready out, both registered)
//   i2c_en, i2c_rw    CTRL[0], CTRL[1]
//   i2c_addr          7-bit target address
//   i2c_start         one-cycle start pulse
//   tx_data/tx_valid  FIFO head towards the engine, tx_ready pops it
//   rx_valid/rx_data  received byte strobe from the engine
//   busy, nack        engine status levels
module apb_i2c_slave #(
  parameter logic [1:0]  SEL_ID     = 2'b01,
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  apb_i2c_slave_if.slave    bus,
  output logic              i2c_en,
  output logic              i2c_rw,
  output logic [6:0]        i2c_addr,
  output logic              i2c_start,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  input  logic              rx_valid,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              busy,
  input  logic              nack
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  localparam logic [ADDR_W-1:0] A_CTRL   = ADDR_W'(8'h00);
  localparam logic [ADDR_W-1:0] A_ADDR   = ADDR_W'(8'h01);
  localparam logic [ADDR_W-1:0] A_TXDATA = ADDR_W'(8'h02);
  localparam logic [ADDR_W-1:0] A_RXDATA = ADDR_W'(8'h03);
  localparam logic [ADDR_W-1:0] A_STATUS = ADDR_W'(8'h04);
  localparam logic [ADDR_W-1:0] A_CMD    = ADDR_W'(8'h05);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic   commit;

  logic              ready_q;
  logic [DATA_W-1:0] rdata_q;
  logic              ctrl_en_q, ctrl_rw_q;
  logic [6:0]        i2c_addr_q;
  logic              i2c_start_q;

  logic [FIFO_DEPTH-1:0][DATA_W-1:0] mem_q;
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q, wr_ptr_d, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0] tx_data_q, head_d;
  logic              tx_valid_q;

  logic [DATA_W-1:0] rx_hold_q;
  logic              rx_full_q, rx_full_d;
  logic              tx_ovf_q, tx_ovf_d;
  logic              rx_ovr_q, rx_ovr_d;

  logic              sel_hit, wr_commit, rd_commit;
  logic              push, pop, push_ok, tx_full, tx_empty;
  logic              status_wr, rx_read;
  logic [DATA_W-1:0] rd_mux;

  assign sel_hit = (bus.sel == SEL_ID);

  // APB next-state; commit marks the access edge of an accepted transfer
  always_comb begin
    state_d = state_q;
    commit  = 1'b0;
    case (state_q)
      ST_IDLE: if (sel_hit && !bus.enable) state_d = ST_WAIT;
      ST_WAIT: begin
        if (sel_hit && bus.enable) begin
          state_d = ST_ACK;
          commit  = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACK:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign wr_commit = commit & bus.write;
  assign rd_commit = commit & ~bus.write;
  assign status_wr = wr_commit && (bus.addr == A_STATUS);
  assign rx_read   = rd_commit && (bus.addr == A_RXDATA);

  assign tx_empty = (count_q == '0);
  assign tx_full  = (count_q == CNT_W'(FIFO_DEPTH));
  assign push     = wr_commit && (bus.addr == A_TXDATA);
  assign pop      = tx_valid_q & tx_ready;
  // A push into a full FIFO survives only if the head leaves in the same cycle
  assign push_ok  = push && (!tx_full || pop);

  // FIFO bookkeeping and the next head so tx_data can be a register
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)     rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (push_ok && !pop)      count_d = count_q + CNT_W'(1);
    else if (!push_ok && pop) count_d = count_q - CNT_W'(1);
    // The byte being written this cycle becomes the head when it lands at rd_ptr_d
    if (push_ok && (wr_ptr_q == rd_ptr_d)) head_d = bus.wdata;
    else                                   head_d = mem_q[rd_ptr_d];
  end

  // Sticky flags: a same-cycle set beats write-1-clear
  always_comb begin
    tx_ovf_d  = tx_ovf_q;
    rx_ovr_d  = rx_ovr_q;
    rx_full_d = rx_full_q;
    if (status_wr && bus.wdata[5]) tx_ovf_d = 1'b0;
    if (push && !push_ok)          tx_ovf_d = 1'b1;
    if (status_wr && bus.wdata[6]) rx_ovr_d = 1'b0;
    if (rx_valid && rx_full_q)     rx_ovr_d = 1'b1;
    if (rx_read)                   rx_full_d = 1'b0;
    if (rx_valid)                  rx_full_d = 1'b1;
  end

  // Read data selection; unmapped and write-only addresses read 0
  always_comb begin
    rd_mux = '0;
    case (bus.addr)
      A_CTRL:   rd_mux = DATA_W'({ctrl_rw_q, ctrl_en_q});
      A_ADDR:   rd_mux = DATA_W'(i2c_addr_q);
      A_RXDATA: rd_mux = rx_hold_q;
      A_STATUS: rd_mux = DATA_W'({rx_ovr_q, tx_ovf_q, nack, busy,
                                  rx_full_q, tx_full, tx_empty});
      default:  rd_mux = '0;
    endcase
  end

  // FSM state and APB response registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      ready_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= (state_d == ST_ACK);
      if (rd_commit) rdata_q <= rd_mux;
    end
  end

  // Control registers and start pulse
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl_en_q   <= 1'b0;
      ctrl_rw_q   <= 1'b0;
      i2c_addr_q  <= '0;
      i2c_start_q <= 1'b0;
    end else begin
      if (wr_commit && (bus.addr == A_CTRL)) begin
        ctrl_en_q <= bus.wdata[0];
        ctrl_rw_q <= bus.wdata[1];
      end
      if (wr_commit && (bus.addr == A_ADDR)) i2c_addr_q <= bus.wdata[6:0];
      i2c_start_q <= wr_commit && (bus.addr == A_CMD) && bus.wdata[0] && ctrl_en_q;
    end
  end

  // TX FIFO storage and registered head
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
    end else begin
      if (push_ok) mem_q[wr_ptr_q] <= bus.wdata;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      tx_data_q  <= head_d;
      tx_valid_q <= (count_d != '0);
    end
  end

  // RX holding register and status flags
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_hold_q <= '0;
      rx_full_q <= 1'b0;
      tx_ovf_q  <= 1'b0;
      rx_ovr_q  <= 1'b0;
    end else begin
      if (rx_valid) rx_hold_q <= rx_data;
      rx_full_q <= rx_full_d;
      tx_ovf_q  <= tx_ovf_d;
      rx_ovr_q  <= rx_ovr_d;
    end
  end

  assign bus.rdata = rdata_q;
  assign bus.ready = ready_q;
  assign i2c_en    = ctrl_en_q;
  assign i2c_rw    = ctrl_rw_q;
  assign i2c_addr  = i2c_addr_q;
  assign i2c_start = i2c_start_q;
  assign tx_data   = tx_data_q;
  assign tx_valid  = tx_valid_q;

endmodule

// File: tb/tb_apb_i2c_slave.sv
// Directed bench for apb_i2c_slave: table of register transfers plus
// hand-written FIFO, RX, CMD, foreign-select and mid-transfer-reset sequences.
module tb_apb_i2c_slave;

  logic       clk;
  logic       reset;
  logic       i2c_en, i2c_rw, i2c_start, tx_valid;
  logic [6:0] i2c_addr;
  logic [7:0] tx_data;
  logic       tx_ready, rx_valid, busy, nack;
  logic [7:0] rx_data;

  int n_cmp  = 0;
  int n_fail = 0;
  int start_cnt = 0;

  apb_i2c_slave_if bus ();

  apb_i2c_slave dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .i2c_en    (i2c_en),
    .i2c_rw    (i2c_rw),
    .i2c_addr  (i2c_addr),
    .i2c_start (i2c_start),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .busy      (busy),
    .nack      (nack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (i2c_start === 1'b1) start_cnt++;

  initial begin
    #200000;
    $display("FAIL global_timeout act=running req=finished");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s act=0x%0h req=0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Called at posedge+1; returns at posedge+1 one cycle after the ACK cycle
  task automatic apb_xfer(input logic [1:0] s, input logic w, input logic [7:0] a,
                          input logic [7:0] d, output logic [7:0] rd,
                          output logic got, output int lat, output logic rdy_after);
    got = 1'b0;
    lat = 0;
    rd  = 8'h00;
    bus.sel = s; bus.enable = 1'b0; bus.write = w; bus.addr = a; bus.wdata = d;
    cyc();
    bus.enable = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      cyc();
      if (!got && bus.ready === 1'b1) begin
        got = 1'b1;
        lat = i;
        rd  = bus.rdata;
        break;
      end
    end
    bus.sel = 2'b00; bus.enable = 1'b0; bus.write = 1'b0;
    cyc();
    rdy_after = bus.ready;
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    logic [7:0] rd; logic got; int lat; logic ra;
    apb_xfer(2'b01, 1'b1, a, d, rd, got, lat, ra);
    check("wr_ready", 32'(got), 32'd1);
  endtask

  task automatic rd_chk(input string name, input logic [7:0] a, input logic [7:0] exp);
    logic [7:0] rd; logic got; int lat; logic ra;
    apb_xfer(2'b01, 1'b0, a, 8'h00, rd, got, lat, ra);
    check({name, "_ready"}, 32'(got), 32'd1);
    check(name, 32'(rd), 32'(exp));
  endtask

  task automatic rx_pulse(input logic [7:0] b);
    rx_valid = 1'b1; rx_data = b;
    cyc();
    rx_valid = 1'b0;
  endtask

  typedef struct {
    logic       w;
    logic [7:0] a;
    logic [7:0] d;
    logic [7:0] exp;
  } vec_t;

  vec_t vt[11];

  initial begin
    logic [7:0] rd; logic got; int lat; logic ra;
    int s0;
    logic [7:0] drain_exp[4];

    vt[0]  = '{1'b1, 8'h00, 8'h03, 8'h00};  // CTRL <- en|rw
    vt[1]  = '{1'b0, 8'h00, 8'h00, 8'h03};
    vt[2]  = '{1'b1, 8'h01, 8'hD5, 8'h00};  // ADDR bit 7 dropped
    vt[3]  = '{1'b0, 8'h01, 8'h00, 8'h55};
    vt[4]  = '{1'b1, 8'h00, 8'hFF, 8'h00};  // CTRL upper bits ignored
    vt[5]  = '{1'b0, 8'h00, 8'h00, 8'h03};
    vt[6]  = '{1'b0, 8'h02, 8'h00, 8'h00};  // TXDATA reads 0
    vt[7]  = '{1'b0, 8'h05, 8'h00, 8'h00};  // CMD reads 0
    vt[8]  = '{1'b0, 8'h7F, 8'h00, 8'h00};  // unmapped reads 0
    vt[9]  = '{1'b1, 8'h7F, 8'hFF, 8'h00};  // unmapped write ignored
    vt[10] = '{1'b0, 8'h04, 8'h00, 8'h01};  // STATUS: tx_empty only

    bus.sel = 2'b00; bus.enable = 1'b0; bus.write = 1'b0;
    bus.addr = 8'h00; bus.wdata = 8'h00;
    tx_ready = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; busy = 1'b0; nack = 1'b0;
    reset = 1'b0;
    repeat (3) cyc();
    check("rst_ready", 32'(bus.ready), 32'd0);
    check("rst_rdata", 32'(bus.rdata), 32'd0);
    check("rst_i2c_en", 32'(i2c_en), 32'd0);
    check("rst_i2c_rw", 32'(i2c_rw), 32'd0);
    check("rst_i2c_addr", 32'(i2c_addr), 32'd0);
    check("rst_i2c_start", 32'(i2c_start), 32'd0);
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    reset = 1'b1;
    cyc();

    // Register table, issued back to back
    for (int i = 0; i < 11; i++) begin
      apb_xfer(2'b01, vt[i].w, vt[i].a, vt[i].d, rd, got, lat, ra);
      check($sformatf("vec%0d_ready", i), 32'(got), 32'd1);
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'd1);
      check($sformatf("vec%0d_ready_drop", i), 32'(ra), 32'd0);
      if (!vt[i].w) check($sformatf("vec%0d_rdata", i), 32'(rd), 32'(vt[i].exp));
    end
    check("ctrl_i2c_en", 32'(i2c_en), 32'd1);
    check("ctrl_i2c_rw", 32'(i2c_rw), 32'd1);
    check("ctrl_i2c_addr", 32'(i2c_addr), 32'h55);

    busy = 1'b1; nack = 1'b1;
    rd_chk("status_busy_nack", 8'h04, 8'h19);
    busy = 1'b0; nack = 1'b0;

    // TX FIFO fill past full, drain in order, clear overflow
    drain_exp[0] = 8'hA1; drain_exp[1] = 8'hB2; drain_exp[2] = 8'hC3; drain_exp[3] = 8'hD4;
    wr(8'h02, 8'hA1);
    check("push1_tx_valid", 32'(tx_valid), 32'd1);
    check("push1_tx_data", 32'(tx_data), 32'hA1);
    wr(8'h02, 8'hB2);
    wr(8'h02, 8'hC3);
    wr(8'h02, 8'hD4);
    rd_chk("status_full", 8'h04, 8'h02);
    wr(8'h02, 8'hE5);
    rd_chk("status_full_ovf", 8'h04, 8'h22);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("drain%0d_valid", i), 32'(tx_valid), 32'd1);
      check($sformatf("drain%0d_data", i), 32'(tx_data), 32'(drain_exp[i]));
      tx_ready = 1'b1;
      cyc();
      tx_ready = 1'b0;
    end
    check("drained_tx_valid", 32'(tx_valid), 32'd0);
    rd_chk("status_empty_ovf", 8'h04, 8'h21);
    wr(8'h04, 8'h20);
    rd_chk("status_ovf_cleared", 8'h04, 8'h01);

    // RX overrun and read-clear of rx_full
    rx_pulse(8'h5A);
    rx_pulse(8'h6B);
    rd_chk("status_rx_ovr", 8'h04, 8'h45);
    rd_chk("rxdata", 8'h03, 8'h6B);
    rd_chk("status_rx_read", 8'h04, 8'h41);
    wr(8'h04, 8'h40);
    rd_chk("status_ovr_cleared", 8'h04, 8'h01);

    // CMD start pulse gated by CTRL.enable
    wr(8'h00, 8'h00);
    s0 = start_cnt;
    wr(8'h05, 8'h01);
    repeat (2) cyc();
    check("cmd_disabled_pulses", 32'(start_cnt - s0), 32'd0);
    wr(8'h00, 8'h01);
    s0 = start_cnt;
    apb_xfer(2'b01, 1'b1, 8'h05, 8'h01, rd, got, lat, ra);
    check("cmd_ready", 32'(got), 32'd1);
    repeat (2) cyc();
    check("cmd_enabled_pulses", 32'(start_cnt - s0), 32'd1);
    // Pulse timing: high in the cycle right after the commit edge
    bus.sel = 2'b01; bus.enable = 1'b0; bus.write = 1'b1; bus.addr = 8'h05; bus.wdata = 8'h01;
    cyc();
    bus.enable = 1'b1;
    cyc();
    check("cmd_start_timing", 32'(i2c_start), 32'd1);
    bus.sel = 2'b00; bus.enable = 1'b0;
    cyc();
    check("cmd_start_single", 32'(i2c_start), 32'd0);

    // Foreign select: no response, no register change
    apb_xfer(2'b10, 1'b1, 8'h00, 8'h00, rd, got, lat, ra);
    check("foreign_sel_ready", 32'(got), 32'd0);
    check("foreign_sel_i2c_en", 32'(i2c_en), 32'd1);
    rd_chk("foreign_sel_ctrl", 8'h00, 8'h01);

    // Reset asserted during WAIT of a TXDATA write
    bus.sel = 2'b01; bus.enable = 1'b0; bus.write = 1'b1; bus.addr = 8'h02; bus.wdata = 8'h99;
    cyc();
    bus.enable = 1'b1;
    #2 reset = 1'b0;
    #1;
    check("midrst_ready", 32'(bus.ready), 32'd0);
    cyc();
    check("midrst_ready_hold", 32'(bus.ready), 32'd0);
    bus.sel = 2'b00; bus.enable = 1'b0; bus.write = 1'b0;
    reset = 1'b1;
    cyc();
    check("midrst_tx_valid", 32'(tx_valid), 32'd0);
    check("midrst_i2c_en", 32'(i2c_en), 32'd0);
    rd_chk("midrst_status", 8'h04, 8'h01);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
